// File: rtl/mem_stage.sv
// RV32 memory stage: EX/MEM register, data-memory handshake FSM,
// store alignment, load extraction and the MEM/WB register.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_alu_out,
  input  logic [31:0] in_rs2_out,
  input  logic [4:0]  in_rd,
  input  logic        in_wb_en,
  input  logic        in_is_load,
  input  logic        in_is_store,
  input  logic [2:0]  in_funct3,
  output logic        mem_stall,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_address,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_byte_enable,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic [31:0] fwd_exmem,
  output logic [31:0] fwd_memwb,
  output logic        out_valid,
  output logic        out_wb_en,
  output logic        out_trap,
  output logic [4:0]  out_rd,
  output logic [31:0] out_result
);

  typedef struct packed {
    logic        valid;
    logic [31:0] alu_out;
    logic [31:0] rs2_out;
    logic [4:0]  rd;
    logic        wb_en;
    logic        is_load;
    logic        is_store;
    logic [2:0]  funct3;
  } exmem_t;

  typedef enum logic {IDLE, WAIT} state_t;

  exmem_t      r_q;
  state_t      state_q;
  state_t      state_d;
  logic [1:0]  off;
  logic        mem_op;
  logic        mis;
  logic        access;
  logic        trap;
  logic [31:0] shifted;
  logic [31:0] load_val;

  // Alignment, request generation and store lane steering
  always_comb begin
    off      = r_q.alu_out[1:0];
    mem_op   = r_q.is_load | r_q.is_store;
    mis      = 1'b0;
    case (r_q.funct3[1:0])
      2'b00:   mis = 1'b0;
      2'b01:   mis = off[0];
      default: mis = (off != 2'b00);
    endcase
    trap         = r_q.valid & mem_op & mis;
    access       = r_q.valid & mem_op & ~mis;
    dmem_read    = access & r_q.is_load;
    dmem_write   = access & r_q.is_store;
    dmem_address = {r_q.alu_out[31:2], 2'b00};
    dmem_wdata   = '0;
    dmem_byte_enable = '0;
    if (dmem_write) begin
      dmem_wdata = r_q.rs2_out << {off, 3'b000};
      case (r_q.funct3[1:0])
        2'b00:   dmem_byte_enable = 4'b0001 << off;
        2'b01:   dmem_byte_enable = 4'b0011 << off;
        default: dmem_byte_enable = 4'b1111;
      endcase
    end
    mem_stall = access & ~dmem_resp;
    fwd_exmem = r_q.alu_out;
    fwd_memwb = out_result;
  end

  // Load data: align the addressed lane down, then extend
  always_comb begin
    shifted  = dmem_rdata >> {off, 3'b000};
    load_val = dmem_rdata;
    case (r_q.funct3)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_val = {24'b0, shifted[7:0]};
      3'b101:  load_val = {16'b0, shifted[15:0]};
      default: load_val = dmem_rdata;
    endcase
  end

  // Next state: WAIT while a request is outstanding
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (access & ~dmem_resp) state_d = WAIT;
      WAIT:    if (dmem_resp | ~access) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // EX/MEM register, frozen while the access is outstanding
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (!mem_stall) begin
      r_q.valid    <= in_valid;
      r_q.alu_out  <= in_alu_out;
      r_q.rs2_out  <= in_rs2_out;
      r_q.rd       <= in_rd;
      r_q.wb_en    <= in_wb_en;
      r_q.is_load  <= in_is_load;
      r_q.is_store <= in_is_store;
      r_q.funct3   <= in_funct3;
    end
  end

  // MEM/WB register; a stalled cycle emits a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_wb_en  <= 1'b0;
      out_trap   <= 1'b0;
      out_rd     <= '0;
      out_result <= '0;
    end else if (!mem_stall) begin
      out_valid  <= r_q.valid;
      out_wb_en  <= r_q.wb_en & ~trap;
      out_trap   <= trap;
      out_rd     <= r_q.rd;
      out_result <= (access & r_q.is_load) ? load_val : r_q.alu_out;
    end else begin
      out_valid  <= 1'b0;
      out_wb_en  <= 1'b0;
      out_trap   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage against a transaction-level model
// with a variable-latency data memory responder.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_alu_out = '0;
  logic [31:0] in_rs2_out = '0;
  logic [4:0]  in_rd = '0;
  logic        in_wb_en = 1'b0;
  logic        in_is_load = 1'b0;
  logic        in_is_store = 1'b0;
  logic [2:0]  in_funct3 = '0;
  logic        mem_stall;
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_address;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_byte_enable;
  logic [31:0] dmem_rdata = '0;
  logic        dmem_resp = 1'b0;
  logic [31:0] fwd_exmem;
  logic [31:0] fwd_memwb;
  logic        out_valid;
  logic        out_wb_en;
  logic        out_trap;
  logic [4:0]  out_rd;
  logic [31:0] out_result;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_alu_out(in_alu_out),
    .in_rs2_out(in_rs2_out), .in_rd(in_rd),
    .in_wb_en(in_wb_en), .in_is_load(in_is_load),
    .in_is_store(in_is_store), .in_funct3(in_funct3),
    .mem_stall(mem_stall),
    .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_address(dmem_address), .dmem_wdata(dmem_wdata),
    .dmem_byte_enable(dmem_byte_enable),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .fwd_exmem(fwd_exmem), .fwd_memwb(fwd_memwb),
    .out_valid(out_valid), .out_wb_en(out_wb_en),
    .out_trap(out_trap), .out_rd(out_rd),
    .out_result(out_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        v;
    bit [31:0] a;
    bit [31:0] d;
    bit [4:0]  rd;
    bit        we;
    bit        ld;
    bit        st;
    bit [2:0]  f3;
    int        lat;
    bit        frd;
    bit [31:0] rdv;
    bit        lr;
    bit [31:0] lres;
    bit        lw;
    bit [31:0] lwd;
    bit [3:0]  lbe;
  } op_t;

  op_t       r;
  op_t       pend;
  op_t       dq[$];
  bit [31:0] mem [64];
  int        waitc;
  bit [31:0] last_rdata;
  bit        chk_en;
  bit        did_rst;

  bit        e_read, e_write, e_stall;
  bit [31:0] e_addr, e_wdata, e_fwd;
  bit [3:0]  e_be;
  bit        e_ov, e_owe, e_trap;
  bit [4:0]  e_rd;
  bit [31:0] e_res;
  bit        lit_pend;
  bit [31:0] lit_val;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic int size_of(bit [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit misal(bit [31:0] a, bit [2:0] f3);
    int sz = size_of(f3);
    return (sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00);
  endfunction

  function automatic bit [31:0] ld_val(bit [31:0] w, bit [31:0] a,
                                       bit [2:0] f3);
    bit [31:0] v;
    byte       sb;
    shortint   sh;
    v  = w >> (8 * a[1:0]);
    sb = v[7:0];
    sh = v[15:0];
    case (f3)
      3'b000:  return int'(sb);
      3'b001:  return int'(sh);
      3'b100:  return v & 32'h0000_00FF;
      3'b101:  return v & 32'h0000_FFFF;
      default: return w;
    endcase
  endfunction

  function automatic op_t idle_op();
    op_t o;
    o = '{default: 0};
    return o;
  endfunction

  function automatic op_t mk(bit ld, bit st, bit [31:0] a,
                             bit [31:0] d, bit [2:0] f3, int lat);
    op_t o;
    o     = '{default: 0};
    o.v   = 1'b1;
    o.ld  = ld;
    o.st  = st;
    o.a   = a;
    o.d   = d;
    o.f3  = f3;
    o.lat = lat;
    o.rd  = 5'($urandom_range(1, 31));
    o.we  = !st;
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t     o;
    int      k;
    bit [2:0] lf [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    k = $urandom_range(0, 9);
    if (k < 2) begin
      o = idle_op();
      o.a = $urandom;
    end else if (k < 4) begin
      o = mk(0, 0, $urandom, $urandom, 3'($urandom), 0);
    end else if (k < 7) begin
      o = mk(1, 0, 32'($urandom_range(0, 255)), $urandom,
             lf[$urandom_range(0, 4)], $urandom_range(0, 3));
    end else begin
      o = mk(0, 1, 32'($urandom_range(0, 255)), $urandom,
             3'($urandom_range(0, 2)), $urandom_range(0, 3));
      o.we = 1'b0;
    end
    return o;
  endfunction

  function automatic op_t next_op();
    if (dq.size() > 0) return dq.pop_front();
    return rand_op();
  endfunction

  task automatic drive(op_t o);
    in_valid    = o.v;
    in_alu_out  = o.a;
    in_rs2_out  = o.d;
    in_rd       = o.rd;
    in_wb_en    = o.we;
    in_is_load  = o.ld;
    in_is_store = o.st;
    in_funct3   = o.f3;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp,
               $time);
    end
  endtask

  // One modelled clock cycle: retire into MEM/WB, capture, respond
  task automatic step();
    bit        acc, resp, tr;
    bit [31:0] rdv;
    bit [3:0]  m;
    int        sz;
    @(posedge clk);
    #1;
    if (!e_stall) begin
      tr       = r.v && (r.ld || r.st) && misal(r.a, r.f3);
      e_ov     = r.v;
      e_rd     = r.rd;
      e_trap   = tr;
      e_owe    = r.we && !tr;
      e_res    = (r.v && r.ld && !tr) ? ld_val(last_rdata, r.a, r.f3)
                                      : r.a;
      lit_pend = r.lr;
      lit_val  = r.lres;
      r        = pend;
      waitc    = 0;
    end else begin
      e_ov     = 1'b0;
      e_owe    = 1'b0;
      e_trap   = 1'b0;
      lit_pend = 1'b0;
    end
    acc  = r.v && (r.ld || r.st) && !misal(r.a, r.f3);
    resp = 1'b0;
    if (acc) begin
      resp = (waitc >= r.lat);
      if (!resp) waitc++;
    end
    rdv        = r.frd ? r.rdv : mem[r.a[7:2]];
    dmem_rdata = resp ? rdv : $urandom;
    dmem_resp  = resp;
    last_rdata = rdv;
    e_read  = acc && r.ld;
    e_write = acc && r.st;
    e_addr  = {r.a[31:2], 2'b00};
    e_fwd   = r.a;
    sz      = size_of(r.f3);
    m       = (sz == 1) ? 4'h1 : (sz == 2) ? 4'h3 : 4'hF;
    e_be    = e_write ? 4'(m << r.a[1:0]) : 4'h0;
    e_wdata = e_write ? r.d << (8 * r.a[1:0]) : 32'h0;
    e_stall = acc && !resp;
    if (resp && e_write)
      for (int i = 0; i < 4; i++)
        if (e_be[i]) mem[r.a[7:2]][8*i +: 8] = e_wdata[8*i +: 8];
    if (!e_stall) begin
      pend = next_op();
      drive(pend);
    end
  endtask

  task automatic model_reset();
    r        = idle_op();
    pend     = idle_op();
    waitc    = 0;
    e_read   = 0; e_write = 0; e_stall = 0;
    e_addr   = 0; e_wdata = 0; e_be = 0; e_fwd = 0;
    e_ov     = 0; e_owe = 0; e_trap = 0; e_rd = 0; e_res = 0;
    lit_pend = 0;
    drive(pend);
    dmem_resp = 1'b0;
  endtask

  // Compare DUT outputs against the model mid-cycle
  always begin
    @(negedge clk or posedge rst);
    #1;
    if (chk_en) begin
      chk("mem_stall", 32'(mem_stall), 32'(e_stall));
      chk("dmem_read", 32'(dmem_read), 32'(e_read));
      chk("dmem_write", 32'(dmem_write), 32'(e_write));
      chk("dmem_address", dmem_address, e_addr);
      chk("dmem_wdata", dmem_wdata, e_wdata);
      chk("dmem_byte_enable", 32'(dmem_byte_enable), 32'(e_be));
      chk("fwd_exmem", fwd_exmem, e_fwd);
      chk("out_valid", 32'(out_valid), 32'(e_ov));
      chk("out_wb_en", 32'(out_wb_en), 32'(e_owe));
      chk("out_trap", 32'(out_trap), 32'(e_trap));
      chk("out_rd", 32'(out_rd), 32'(e_rd));
      chk("out_result", out_result, e_res);
      chk("fwd_memwb", fwd_memwb, e_res);
      if (lit_pend) chk("lit_result", out_result, lit_val);
      if (r.lw && e_write) begin
        chk("lit_wdata", dmem_wdata, r.lwd);
        chk("lit_be", 32'(dmem_byte_enable), 32'(r.lbe));
      end
    end
  end

  initial begin
    op_t o;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    model_reset();
    last_rdata = '0;
    chk_en = 1'b1;

    o = mk(1, 0, 32'h100, 0, 3'b010, 3);
    o.frd = 1; o.rdv = 32'hDEADBEEF; o.lr = 1; o.lres = 32'hDEADBEEF;
    dq.push_back(o);
    o = mk(1, 0, 32'h103, 0, 3'b000, 0);
    o.frd = 1; o.rdv = 32'h80FF_FFFF; o.lr = 1; o.lres = 32'hFFFF_FF80;
    dq.push_back(o);
    o = mk(1, 0, 32'h103, 0, 3'b100, 0);
    o.frd = 1; o.rdv = 32'h80FF_FFFF; o.lr = 1; o.lres = 32'h0000_0080;
    dq.push_back(o);
    o = mk(0, 1, 32'h202, 32'h0000_1234, 3'b001, 2);
    o.lw = 1; o.lwd = 32'h1234_0000; o.lbe = 4'b1100;
    dq.push_back(o);
    o = mk(0, 1, 32'h101, 32'hCAFE_F00D, 3'b010, 0);
    o.lr = 1; o.lres = 32'h101;
    dq.push_back(o);
    o = mk(0, 0, 32'h55, 0, 3'b000, 0);
    o.lr = 1; o.lres = 32'h55;
    dq.push_back(o);
    dq.push_back(mk(1, 0, 32'h40, 0, 3'b010, 2));
    for (int i = 0; i < 30; i++) dq.push_back(rand_op());
    dq.push_back(mk(1, 0, 32'h44, 0, 3'b010, 20));
    for (int i = 0; i < 4; i++) dq.push_back(idle_op());

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 600; i++) begin
      step();
      if (!did_rst && r.lat == 20 && waitc == 2) begin
        did_rst = 1'b1;
        #1;
        model_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
      end
    end
    if (!did_rst) begin
      n_bad++;
      $display("FAIL reset_in_wait: got 0 expected 1");
    end

    @(negedge clk);
    #3;
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
